// File: rtl/sad_pkg.sv
// Shared constants and state encoding for the SAD result SRAM arbiter.
package sad_pkg;

    // Result SRAM geometry: 128 words of 32 bits.
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    // ARB: normal two-port arbitration; CLEAR: full-memory zeroing sweep.
    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } sad_state_e;

endpackage

// File: rtl/sad_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on contention
// the port named by pointer wins. The pointer itself lives in the parent.
module sad_rr_arb2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] gnt
);

    // Pick the winner from the current request vector and pointer.
    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = pointer ? 2'b10 : 2'b01;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/sad_result_arbiter.sv
// Arbitrates SAD-engine (port 0) and host (port 1) accesses onto a single
// synchronous result SRAM, and runs a full-memory clear sweep on request.
// SRAM command outputs are registered; read data returns two cycles after
// the grant and is flagged per port with Rd_Valid0/1.
module sad_result_arbiter #(
    parameter int unsigned AW = sad_pkg::AW,
    parameter int unsigned DW = sad_pkg::DW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          RW0,
    input  logic          RW1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] Wdata0,
    input  logic [DW-1:0] Wdata1,
    output logic          Gnt0,
    output logic          Gnt1,
    output logic          Rd_Valid0,
    output logic          Rd_Valid1,
    output logic [DW-1:0] Rd_Data,
    input  logic          Clr_Start,
    output logic          Busy,
    output logic          Clr_Done,
    output logic          Sram_En,
    output logic          Sram_RW,
    output logic [AW-1:0] Sram_Addr,
    output logic [DW-1:0] Sram_Din,
    input  logic [DW-1:0] Sram_Dout
);

    import sad_pkg::*;

    sad_state_e    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [AW:0]   clr_cnt_q, clr_cnt_d;
    logic [AW:0]   clr_cnt_nxt;
    logic          sram_en_q, sram_en_d;
    logic          sram_rw_q, sram_rw_d;
    logic [AW-1:0] sram_addr_q, sram_addr_d;
    logic [DW-1:0] sram_din_q, sram_din_d;
    logic [1:0]    rd_pend_q, rd_pend_d;
    logic [1:0]    rd_valid_q, rd_valid_d;
    logic          busy_q, busy_d;
    logic          clr_done_q, clr_done_d;

    logic [1:0]    arb_req;
    logic [1:0]    arb_gnt;
    logic [1:0]    gnt;
    logic          grant_ok;

    assign arb_req = {Req1, Req0};

    sad_rr_arb2 u_rr_arb2 (
        .req     (arb_req),
        .pointer (ptr_q),
        .gnt     (arb_gnt)
    );

    // Grants are only issued in ARB, and Clr_Start pre-empts any request.
    always_comb begin
        grant_ok = (state_q == ARB) && !Clr_Start;
        gnt      = grant_ok ? arb_gnt : 2'b00;
    end

    // The counter is one bit wider than the address so that the carry into
    // its MSB marks the final word without comparing against a wrapped value.
    assign clr_cnt_nxt = clr_cnt_q + 1'b1;

    // Next-state, SRAM command and read-tracking logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        clr_cnt_d   = clr_cnt_q;
        sram_en_d   = 1'b0;
        sram_rw_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        rd_pend_d   = 2'b00;
        rd_valid_d  = rd_pend_q;
        busy_d      = 1'b0;
        clr_done_d  = 1'b0;

        case (state_q)
            ARB: begin
                if (Clr_Start) begin
                    // Word 0 is issued from the start cycle itself so that
                    // word k lands on the SRAM k cycles after entering CLEAR.
                    state_d     = CLEAR;
                    clr_cnt_d   = {{AW{1'b0}}, 1'b1};
                    sram_en_d   = 1'b1;
                    sram_rw_d   = 1'b1;
                    sram_addr_d = '0;
                    sram_din_d  = '0;
                    busy_d      = 1'b1;
                end else if (gnt != 2'b00) begin
                    sram_en_d = 1'b1;
                    if (gnt[1]) begin
                        sram_rw_d   = RW1;
                        sram_addr_d = Addr1;
                        sram_din_d  = Wdata1;
                    end else begin
                        sram_rw_d   = RW0;
                        sram_addr_d = Addr0;
                        sram_din_d  = Wdata0;
                    end
                    if (arb_req == 2'b11) begin
                        ptr_d = gnt[0];
                    end
                    rd_pend_d = gnt & ~{RW1, RW0};
                end
            end

            CLEAR: begin
                busy_d      = 1'b1;
                sram_en_d   = 1'b1;
                sram_rw_d   = 1'b1;
                sram_addr_d = clr_cnt_q[AW-1:0];
                sram_din_d  = '0;
                if (clr_cnt_nxt[AW]) begin
                    state_d    = ARB;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_nxt;
                end
            end

            default: begin
                state_d = ARB;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ARB;
            ptr_q       <= 1'b0;
            clr_cnt_q   <= '0;
            sram_en_q   <= 1'b0;
            sram_rw_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            rd_pend_q   <= 2'b00;
            rd_valid_q  <= 2'b00;
            busy_q      <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            clr_cnt_q   <= clr_cnt_d;
            sram_en_q   <= sram_en_d;
            sram_rw_q   <= sram_rw_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            rd_pend_q   <= rd_pend_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign Gnt0      = gnt[0];
    assign Gnt1      = gnt[1];
    assign Rd_Valid0 = rd_valid_q[0];
    assign Rd_Valid1 = rd_valid_q[1];
    assign Rd_Data   = Sram_Dout;
    assign Busy      = busy_q;
    assign Clr_Done  = clr_done_q;
    assign Sram_En   = sram_en_q;
    assign Sram_RW   = sram_rw_q;
    assign Sram_Addr = sram_addr_q;
    assign Sram_Din  = sram_din_q;

endmodule

// File: tb/tb_sad_result_arbiter.sv
// Scoreboard bench for sad_result_arbiter: a behavioural model predicts
// grants, per-cycle SRAM commands and read returns; a monitor compares.
module tb_sad_result_arbiter;

    import sad_pkg::*;

    localparam int unsigned WORDS = 1 << AW;

    logic          Clk = 1'b0;
    logic          Rst, Req0, Req1, RW0, RW1, Clr_Start;
    logic [AW-1:0] Addr0, Addr1, Sram_Addr;
    logic [DW-1:0] Wdata0, Wdata1, Rd_Data, Sram_Din, Sram_Dout;
    logic          Gnt0, Gnt1, Rd_Valid0, Rd_Valid1, Busy, Clr_Done;
    logic          Sram_En, Sram_RW;

    always #5 Clk = ~Clk;

    sad_result_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0(Req0), .Req1(Req1), .RW0(RW0), .RW1(RW1),
        .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Rd_Valid0(Rd_Valid0), .Rd_Valid1(Rd_Valid1),
        .Rd_Data(Rd_Data), .Clr_Start(Clr_Start), .Busy(Busy), .Clr_Done(Clr_Done),
        .Sram_En(Sram_En), .Sram_RW(Sram_RW), .Sram_Addr(Sram_Addr),
        .Sram_Din(Sram_Din), .Sram_Dout(Sram_Dout)
    );

    // Synchronous single-port SRAM: read data appears the cycle after sampling.
    logic [DW-1:0] sram_mem [WORDS];
    always @(posedge Clk) begin
        if (Sram_En) begin
            if (Sram_RW) sram_mem[Sram_Addr] <= Sram_Din;
            else         Sram_Dout <= sram_mem[Sram_Addr];
        end
    end

    typedef struct {
        logic          v;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        logic          en;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          busy;
        logic          done;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } rd_t;

    req_t          pend [2];
    cmd_t          cmd_q [$];
    rd_t           rd_q0 [$];
    rd_t           rd_q1 [$];
    logic [DW-1:0] ref_mem [WORDS];
    logic          m_ptr;
    logic          m_clearing;
    int unsigned   m_clr_addr;
    logic          clr_in, rst_in;
    int unsigned   cyc = 0;
    int            errors = 0;
    int            checks = 0;
    bit            mon_en = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[p].v    = 1'b1;
        pend[p].rw   = rw;
        pend[p].addr = a;
        pend[p].data = d;
    endtask

    task automatic drive();
        Rst       = rst_in;
        Clr_Start = clr_in;
        Req0 = pend[0].v; RW0 = pend[0].rw; Addr0 = pend[0].addr; Wdata0 = pend[0].data;
        Req1 = pend[1].v; RW1 = pend[1].rw; Addr1 = pend[1].addr; Wdata1 = pend[1].data;
    endtask

    // Reference model for one cycle: decides who should be granted, what the
    // SRAM should see next cycle, and which read data each port should get.
    task automatic model_step();
        logic [1:0] eg;
        cmd_t       c;
        int         w;
        eg = 2'b00;
        w  = -1;
        c.en = 1'b0; c.rw = 1'b0; c.addr = '0; c.din = '0; c.busy = 1'b0; c.done = 1'b0;
        if (!rst_in && !m_clearing && clr_in) begin
            m_clearing = 1'b1;
            m_clr_addr = 0;
        end
        if (rst_in) begin
            m_ptr      = 1'b0;
            m_clearing = 1'b0;
            while (rd_q0.size() > 0 && rd_q0[$].due > cyc) void'(rd_q0.pop_back());
            while (rd_q1.size() > 0 && rd_q1[$].due > cyc) void'(rd_q1.pop_back());
        end else if (m_clearing) begin
            c.en = 1'b1; c.rw = 1'b1; c.addr = AW'(m_clr_addr); c.busy = 1'b1;
            ref_mem[m_clr_addr] = '0;
            if (m_clr_addr == WORDS - 1) begin
                c.done     = 1'b1;
                m_clearing = 1'b0;
            end
            m_clr_addr++;
        end else begin
            if (pend[0].v && pend[1].v) begin
                w     = m_ptr ? 1 : 0;
                m_ptr = (w == 0);
            end else if (pend[0].v) w = 0;
            else if (pend[1].v)     w = 1;
            if (w >= 0) begin
                eg[w]  = 1'b1;
                c.en   = 1'b1;
                c.rw   = pend[w].rw;
                c.addr = pend[w].addr;
                c.din  = pend[w].data;
                if (pend[w].rw) begin
                    ref_mem[pend[w].addr] = pend[w].data;
                end else if (w == 0) begin
                    rd_q0.push_back('{data: ref_mem[pend[w].addr], due: cyc + 2});
                end else begin
                    rd_q1.push_back('{data: ref_mem[pend[w].addr], due: cyc + 2});
                end
                pend[w].v = 1'b0;
            end
        end
        chk("gnt", {62'd0, Gnt1, Gnt0}, {62'd0, eg});
        cmd_q.push_back(c);
        mon_en = 1'b1;
    endtask

    task automatic cycle();
        drive();
        @(negedge Clk);
        model_step();
        @(posedge Clk);
        #1;
        clr_in = 1'b0;
        rst_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while ((pend[0].v || pend[1].v || m_clearing) && n < max) begin
            cycle();
            n++;
        end
        checks++;
        if (pend[0].v || pend[1].v || m_clearing) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", max);
        end
    endtask

    // Monitor: compares registered outputs against the scoreboard each cycle.
    initial begin
        cmd_t c;
        rd_t  r;
        logic e0, e1;
        forever begin
            @(posedge Clk);
            #3;
            if (mon_en) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_queue: empty at cyc %0d, required an entry", cyc);
                end else begin
                    c = cmd_q.pop_front();
                    chk("sram_en", {63'd0, Sram_En}, {63'd0, c.en});
                    chk("busy", {63'd0, Busy}, {63'd0, c.busy});
                    chk("clr_done", {63'd0, Clr_Done}, {63'd0, c.done});
                    if (c.en) begin
                        chk("sram_rw", {63'd0, Sram_RW}, {63'd0, c.rw});
                        chk("sram_addr", 64'(Sram_Addr), 64'(c.addr));
                        chk("sram_din", 64'(Sram_Din), 64'(c.din));
                    end
                end
                e0 = (rd_q0.size() > 0) && (rd_q0[0].due == cyc);
                e1 = (rd_q1.size() > 0) && (rd_q1[0].due == cyc);
                chk("rd_valid0", {63'd0, Rd_Valid0}, {63'd0, e0});
                chk("rd_valid1", {63'd0, Rd_Valid1}, {63'd0, e1});
                if (e0) begin
                    r = rd_q0.pop_front();
                    if (Rd_Valid0) chk("rd_data0", 64'(Rd_Data), 64'(r.data));
                end
                if (e1) begin
                    r = rd_q1.pop_front();
                    if (Rd_Valid1) chk("rd_data1", 64'(Rd_Data), 64'(r.data));
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < int'(WORDS); i++) begin
            v = $urandom;
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        for (int p = 0; p < 2; p++) begin
            pend[p].v = 1'b0; pend[p].rw = 1'b0; pend[p].addr = '0; pend[p].data = '0;
        end
        m_ptr = 1'b0; m_clearing = 1'b0; m_clr_addr = 0;
        clr_in = 1'b0; rst_in = 1'b1;
        drive();
        @(posedge Clk);
        #1;

        // Reset state.
        rst_in = 1'b1; cycle();
        rst_in = 1'b1; cycle();
        idle(2);

        // Engine write then host read of the same word.
        set_req(0, 1'b1, 7'd5, 32'hDEADBEEF); cycle();
        set_req(1, 1'b0, 7'd5, $urandom);     cycle();
        idle(3);

        // Sustained contention: alternating grants, no idle SRAM cycle.
        for (int i = 0; i < 4; i++) begin
            if (!pend[0].v) set_req(0, 1'($urandom), 7'($urandom), $urandom);
            if (!pend[1].v) set_req(1, 1'($urandom), 7'($urandom), $urandom);
            cycle();
        end
        run_until_idle(10);
        idle(3);

        // Host read of the top word just before a clear; clear races Req0;
        // a second Clr_Start mid-sweep must be ignored.
        set_req(0, 1'b1, 7'd127, 32'hA5A51234); cycle();
        set_req(1, 1'b0, 7'd127, $urandom);     cycle();
        set_req(0, 1'b0, 7'd5, $urandom);
        clr_in = 1'b1; cycle();
        for (int i = 0; i < 140; i++) begin
            if (i == 9) clr_in = 1'b1;
            cycle();
        end
        idle(3);

        // Move pointer to port 1, then reset mid-sweep: pointer returns to 0.
        set_req(0, 1'b0, 7'd1, $urandom);
        set_req(1, 1'b0, 7'd2, $urandom);
        cycle();
        cycle();
        clr_in = 1'b1; cycle();
        idle(39);
        rst_in = 1'b1; cycle();
        set_req(0, 1'b0, 7'd40, $urandom);
        set_req(1, 1'b0, 7'd39, $urandom);
        cycle();
        run_until_idle(10);
        idle(3);

        // Randomised traffic with occasional clear sweeps.
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p].v && ($urandom % 3 != 0)) begin
                    set_req(p, 1'($urandom), ($urandom % 8 == 0) ? 7'd127 : 7'($urandom % 16), $urandom);
                end
            end
            if (!m_clearing && ($urandom % 250 == 0)) clr_in = 1'b1;
            cycle();
        end
        run_until_idle(300);
        idle(4);

        checks++;
        if (rd_q0.size() != 0 || rd_q1.size() != 0) begin
            errors++;
            $display("FAIL rd_outstanding: %0d/%0d reads never returned, required 0/0", rd_q0.size(), rd_q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sad_result_arbiter.md
SAD_RESULT_ARBITER -- requirements
Module: sad_result_arbiter

Interface
REQ-001 Parameter AW, 7, result SRAM address width (128 words).
REQ-002 Parameter DW, 32, result SRAM data width.
REQ-003 Clk  in  1  clock; all state updates on rising edge.
REQ-004 Rst  in  1  reset, synchronous, active-high.
REQ-005 Req0, Req1  in  1 each  access request, port 0 = SAD engine, port 1 = host.
REQ-006 RW0, RW1  in  1 each  1 = write, 0 = read, valid while the matching Req is high.
REQ-007 Addr0, Addr1  in  AW each  word address.
REQ-008 Wdata0, Wdata1  in  DW each  write data.
REQ-009 Gnt0, Gnt1  out  1 each  combinational accept in the request cycle.
REQ-010 Rd_Valid0, Rd_Valid1  out  1 each  read data valid for that port.
REQ-011 Rd_Data  out  DW  shared read data, equal to Sram_Dout.
REQ-012 Clr_Start  in  1  one-cycle pulse that starts a full-memory clear sweep.
REQ-013 Busy  out  1  clear sweep in progress; Clr_Done  out  1  one-cycle pulse at sweep end.
REQ-014 Sram_En, Sram_RW  out  1 each; Sram_Addr  out  AW; Sram_Din  out  DW; registered SRAM command.
REQ-015 Sram_Dout  in  DW  SRAM read data, valid one cycle after the SRAM samples a read.

Function
REQ-016 The FSM SHALL have two states: ARB and CLEAR.
REQ-017 In ARB, with one request high, that port SHALL be granted in the same cycle.
REQ-018 In ARB, with both requests high, the grant SHALL go to the port named by a round-robin pointer, and the pointer SHALL then move to the other port.
REQ-019 At most one Gnt SHALL be high per cycle, and no Gnt SHALL be issued in CLEAR or in the Clr_Start cycle.
REQ-020 A granted access (port x, cycle t) SHALL produce registered Sram_En=1, Sram_RW=RWx, Sram_Addr=Addrx, Sram_Din=Wdatax in cycle t+1.
REQ-021 Sram_En SHALL be 0 in any cycle that follows a cycle with no grant and no clear activity.
REQ-022 For a granted read, Rd_Validx SHALL be 1 in cycle t+2 only, and Rd_Data SHALL then hold Memory[Addrx].
REQ-023 Throughput SHALL be one access per cycle, and back-to-back grants SHALL pipeline without bubbles.
REQ-024 A requester SHALL hold Req, RW, Addr and Wdata stable until it is granted, and may change them in the cycle after the grant.
REQ-025 Clr_Start in ARB SHALL enter CLEAR, and it SHALL take priority over any requests in that same cycle.
REQ-026 In CLEAR, the block SHALL issue writes of 0 to addresses 0 through 2^AW-1, one per cycle, in ascending order, so Sram_Addr=k in the k-th cycle after entry.
REQ-027 After the write to address 2^AW-1 is issued, the FSM SHALL return to ARB; Clr_Done SHALL pulse in the cycle that write appears on Sram_*; Busy SHALL fall in the following cycle.
REQ-028 Clr_Start during CLEAR SHALL be ignored.
REQ-029 Reads already in flight when CLEAR starts SHALL still complete with their Rd_Valid.
REQ-030 The clear address counter SHALL be AW+1 bits wide so that the terminal count is detected without wrap ambiguity.

Reset
REQ-031 Rst SHALL force state ARB and the round-robin pointer to port 0.
REQ-032 Rst SHALL clear the clear counter and force Sram_En, Sram_RW, Sram_Addr, Sram_Din, Rd_Valid0/1, Busy and Clr_Done to 0.
REQ-033 Rst during CLEAR SHALL abort the sweep with no Clr_Done pulse.
REQ-034 Rst SHALL cancel any pending Rd_Valid.

Structure
REQ-035 A shared package sad_pkg SHALL hold the constants AW and DW and the state enum {ARB, CLEAR}.
REQ-036 The 2-way round-robin grant logic SHALL be a sub-module named sad_rr_arb2, with inputs req[1:0] and pointer, and outputs gnt[1:0].

Verification
REQ-037 Req0 write Addr=5, Wdata=0xDEADBEEF, then Req1 read Addr=5 -> Gnt0 in t0, Gnt1 in t1, Rd_Valid1 in t1+2 with Rd_Data=0xDEADBEEF.
REQ-038 Req0 and Req1 both held high for 4 cycles -> grant order 0,1,0,1 with no idle Sram_En cycle.
REQ-039 Clr_Start in the same cycle as Req0 -> no Gnt; Sram_Addr steps 0..127 with Sram_Din=0; Clr_Done at step 127; a read of Addr=5 after the sweep returns 0.
REQ-040 Rst asserted at clear step 40 -> Busy=0 and Sram_En=0 next cycle, no Clr_Done, pointer=0.
REQ-041 Host read of Addr=127 granted one cycle before Clr_Start -> Rd_Valid1 still asserted in cycle t+2 with the pre-clear data.
REQ-042 Clr_Start pulsed again at clear step 10 -> sweep continues unchanged, with exactly one Clr_Done.
